env_port_sched: RTL and testbench
=================================

// Module: env_port_sched
// PURPOSE
//  Shares the environment grid's single write port among NUM_REQ ant requesters and a background pheromone-decay sweeper.
//  The sweeper walks every cell, reads it via the lookup port and writes back a saturating-decremented signal.
//  Sits between the ant array and the environment register file; owns write_* and arbitrates the lookup port.
// PARAMETERS
//  NUM_REQ      4   number of ant write requesters
//  DECAY_STEP   1   amount subtracted from each nonzero cell signal per sweep
//  STARVE_LIM   8   consecutive deferred sweep writes before the sweeper forces one port cycle
// PORTS
//  newLocClock     in   1                    clock; all state on rising edge
//  RESET_SIM_N     in   1                    asynchronous, active-low reset
//  req_valid       in   NUM_REQ              ant write request; held with data until granted
//  req_X/req_Y     in   NUM_REQ x X/Y_bits   target cell per requester
//  req_signal      in   NUM_REQ x SIGNAL_bits  signal to write
//  req_sugar       in   NUM_REQ              sugar bit to write
//  req_grant       out  NUM_REQ              one-hot combinational grant; accept = valid & grant
//  decay_start     in   1                    1-cycle pulse: start a sweep (ignored while busy)
//  decay_busy      out  1                    high from first SWEEP_READ through DONE
//  decay_done      out  1                    1-cycle pulse on sweep completion
//  ant_lookup_X/Y  in   X_bits/Y_bits        ant-side lookup request
//  ant_lookup_stall out 1                    ant lookup result invalid this cycle
//  lookup_X/Y      out  X_bits/Y_bits        to environment lookup port (combinational mux)
//  lookup_signal   in   SIGNAL_bits          environment lookup data
//  lookup_sugar    in   1                    environment lookup data
//  write_X/Y       out  X_bits/Y_bits        registered write address
//  write_signal    out  SIGNAL_bits          registered write data
//  write_sugar     out  1                    registered write data
//  write_flag      out  1                    registered 1-cycle write strobe
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, RR pointer 0, sweep cell (0,0), starve count 0.
//  - Write latency: grant/issue in cycle t -> write_* valid and write_flag=1 in t+1 only; environment commits at end of t+1.
//  - RR arbiter: grant lowest valid index >= pointer (wrapping); pointer <= granted index+1 mod NUM_REQ.
//    At most one grant per cycle; no grant while the sweeper holds the port.
//  - FSM IDLE: decay_start -> SWEEP_READ at cell (0,0).
//  - SWEEP_READ: lookup_X/Y = sweep cell, ant_lookup_stall = 1; capture signal/sugar at cycle end.
//    Retry same cell if write_flag && write_X/Y == sweep cell (stale data).
//    If captured signal == 0: advance cell, stay in READ (no port use).
//    Otherwise -> SWEEP_WRITE.
//  - SWEEP_WRITE: if any req_valid and starve < STARVE_LIM: grant ant, starve++, stay.
//    If that ant's X/Y == sweep cell -> back to SWEEP_READ for the same cell (ant data wins).
//    Otherwise (no requests or starve == STARVE_LIM): issue write with
//      sig' = (sig > DECAY_STEP) ? sig - DECAY_STEP : 0; sugar unchanged.
//    Then starve <= 0, advance cell, -> SWEEP_READ.
//  - Outside SWEEP_READ: lookup_X/Y = ant_lookup_X/Y, ant_lookup_stall = 0.
//  - Cell advance: X increments; at PIXELS_X-1, X <= 0 and Y++.
//    Advancing past (PIXELS_X-1, PIXELS_Y-1) -> DONE.
//  - DONE: decay_done = 1 for one cycle, cell <= (0,0) -> IDLE. decay_start in DONE ignored.
//  - Ant grants continue in IDLE, READ and DONE with normal RR.
//  - Reset mid-sweep aborts immediately; no partial write is emitted after reset release.
// STRUCTURE
//  - env_pkg: typedef sched_state_t {IDLE, SWEEP_READ, SWEEP_WRITE, DONE};
//    typedef env_wr_t {x, y, signal, sugar}; sized from X_bits/Y_bits/SIGNAL_bits.
//  - Sub-module rr_arbiter #(N) (req, ptr, enable -> grant, idx).
//  - Sweep FSM, cell counter and write register live in the top module.
// TESTING
//  1. Reset: RESET_SIM_N=0 mid-sweep -> all outputs 0, decay_busy=0. Next decay_start restarts at (0,0).
//  2. RR: req_valid=4'b1011 held -> grants 0,1,3,0 in consecutive cycles; write_flag 1 cycle after each grant.
//  3. Decay: cell (2,1) sig=5, DECAY_STEP=1 -> sweep writes (2,1) sig=4, sugar preserved.
//     sig=1 -> 0; sig=0 -> no write_flag.
//  4. Starvation: all ants valid continuously during SWEEP_WRITE -> 8 ant grants, then a forced sweep write, starve reset.
//  5. Hazard: ant granted for the sweep cell in SWEEP_WRITE.
//     -> sweeper re-reads, retries once (write_flag match), then decays the ant's value (e.g. ant writes 7 -> final 6).
//  6. Completion: 4x4 grid, all sig=0, no ants -> decay_done pulses 17 cycles after decay_start
//     (16 READ + 1 DONE); decay_start while busy has no effect.

Source files
------------

// File: rtl/env_pkg.sv
// Shared types and grid geometry for the environment write-port scheduler.
package env_pkg;

  localparam int PIXELS_X    = 4;
  localparam int PIXELS_Y    = 4;
  localparam int X_BITS      = 2;
  localparam int Y_BITS      = 2;
  localparam int SIGNAL_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP_READ,
    SWEEP_WRITE,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [X_BITS-1:0]      x;
    logic [Y_BITS-1:0]      y;
    logic [SIGNAL_BITS-1:0] signal;
    logic                   sugar;
  } env_wr_t;

  // Saturating decrement: anything at or below the step collapses to zero.
  function automatic logic [SIGNAL_BITS-1:0] decay_sat(input logic [SIGNAL_BITS-1:0] sig,
                                                       input int step);
    if (int'(sig) > step) return sig - SIGNAL_BITS'(step);
    else                  return '0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or above the pointer, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_enable,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic w_found;
  int   w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    if (i_enable) begin
      for (int i = 0; i < N; i++) begin
        w_k = (int'(i_ptr) + i) % N;
        if (!w_found && i_req[w_k]) begin
          o_grant[w_k] = 1'b1;
          o_idx        = w_k[IW-1:0];
          w_found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/env_port_sched.sv
// Shares the environment write port between ant requesters and a pheromone-decay sweeper,
// and steals the lookup port while the sweeper reads cells.
module env_port_sched
  import env_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DECAY_STEP = 1,
  parameter int STARVE_LIM = 8
) (
  input  logic                                 newLocClock,
  input  logic                                 RESET_SIM_N,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][X_BITS-1:0]       req_X,
  input  logic [NUM_REQ-1:0][Y_BITS-1:0]       req_Y,
  input  logic [NUM_REQ-1:0][SIGNAL_BITS-1:0]  req_signal,
  input  logic [NUM_REQ-1:0]                   req_sugar,
  output logic [NUM_REQ-1:0]                   req_grant,
  input  logic                                 decay_start,
  output logic                                 decay_busy,
  output logic                                 decay_done,
  input  logic [X_BITS-1:0]                    ant_lookup_X,
  input  logic [Y_BITS-1:0]                    ant_lookup_Y,
  output logic                                 ant_lookup_stall,
  output logic [X_BITS-1:0]                    lookup_X,
  output logic [Y_BITS-1:0]                    lookup_Y,
  input  logic [SIGNAL_BITS-1:0]               lookup_signal,
  input  logic                                 lookup_sugar,
  output logic [X_BITS-1:0]                    write_X,
  output logic [Y_BITS-1:0]                    write_Y,
  output logic [SIGNAL_BITS-1:0]               write_signal,
  output logic                                 write_sugar,
  output logic                                 write_flag
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  sched_state_t            r_state, w_next_state;
  logic [X_BITS-1:0]       r_cell_x;
  logic [Y_BITS-1:0]       r_cell_y;
  logic [SW-1:0]           r_starve;
  logic [IW-1:0]           r_ptr;
  logic [SIGNAL_BITS-1:0]  r_sig;
  logic                    r_sugar;
  env_wr_t                 r_wr;
  logic                    r_wr_flag;

  logic [NUM_REQ-1:0]      w_grant;
  logic [IW-1:0]           w_idx;
  logic                    w_any, w_arb_en, w_last, w_wr_hit, w_ant_hit;
  logic                    w_adv, w_capture, w_sweep_wr, w_starve_inc, w_cell_clr;

  // The sweeper only takes the port from the ants once they have starved it long enough.
  assign w_arb_en = !((r_state == SWEEP_WRITE) && (r_starve >= SW'(STARVE_LIM)));

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .i_enable (w_arb_en),
    .o_grant  (w_grant),
    .o_idx    (w_idx)
  );

  assign w_any     = |w_grant;
  assign w_last    = (r_cell_x == X_BITS'(PIXELS_X - 1)) && (r_cell_y == Y_BITS'(PIXELS_Y - 1));
  assign w_wr_hit  = r_wr_flag && (r_wr.x == r_cell_x) && (r_wr.y == r_cell_y);
  assign w_ant_hit = w_any && (req_X[w_idx] == r_cell_x) && (req_Y[w_idx] == r_cell_y);

  assign req_grant        = w_grant;
  assign decay_busy       = (r_state != IDLE);
  assign decay_done       = (r_state == DONE);
  assign ant_lookup_stall = (r_state == SWEEP_READ);
  assign lookup_X         = ant_lookup_stall ? r_cell_x : ant_lookup_X;
  assign lookup_Y         = ant_lookup_stall ? r_cell_y : ant_lookup_Y;
  assign write_X          = r_wr.x;
  assign write_Y          = r_wr.y;
  assign write_signal     = r_wr.signal;
  assign write_sugar      = r_wr.sugar;
  assign write_flag       = r_wr_flag;

  // A read retries while the cell has an ant write in flight, so the captured value is never stale.
  always_comb begin
    w_next_state = r_state;
    w_adv        = 1'b0;
    w_capture    = 1'b0;
    w_sweep_wr   = 1'b0;
    w_starve_inc = 1'b0;
    w_cell_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (decay_start) w_next_state = SWEEP_READ;
      end
      SWEEP_READ: begin
        if (w_wr_hit || w_ant_hit) begin
          w_next_state = SWEEP_READ;
        end else if (lookup_signal == '0) begin
          w_adv        = 1'b1;
          w_next_state = w_last ? DONE : SWEEP_READ;
        end else begin
          w_capture    = 1'b1;
          w_next_state = SWEEP_WRITE;
        end
      end
      SWEEP_WRITE: begin
        if (w_any) begin
          w_starve_inc = 1'b1;
          if (w_ant_hit) w_next_state = SWEEP_READ;
        end else begin
          w_sweep_wr   = 1'b1;
          w_adv        = 1'b1;
          w_next_state = w_last ? DONE : SWEEP_READ;
        end
      end
      DONE: begin
        w_cell_clr   = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) r_state <= IDLE;
    else              r_state <= w_next_state;
  end

  always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      r_cell_x <= '0;
      r_cell_y <= '0;
    end else if (w_cell_clr) begin
      r_cell_x <= '0;
      r_cell_y <= '0;
    end else if (w_adv) begin
      if (r_cell_x == X_BITS'(PIXELS_X - 1)) begin
        r_cell_x <= '0;
        r_cell_y <= w_last ? '0 : r_cell_y + Y_BITS'(1);
      end else begin
        r_cell_x <= r_cell_x + X_BITS'(1);
      end
    end
  end

  always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      r_starve <= '0;
      r_ptr    <= '0;
      r_sig    <= '0;
      r_sugar  <= 1'b0;
    end else begin
      if (w_sweep_wr)        r_starve <= '0;
      else if (w_starve_inc) r_starve <= r_starve + SW'(1);
      if (w_any) r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
      if (w_capture) begin
        r_sig   <= lookup_signal;
        r_sugar <= lookup_sugar;
      end
    end
  end

  always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      r_wr      <= '0;
      r_wr_flag <= 1'b0;
    end else if (w_sweep_wr) begin
      r_wr      <= '{x: r_cell_x, y: r_cell_y, signal: decay_sat(r_sig, DECAY_STEP), sugar: r_sugar};
      r_wr_flag <= 1'b1;
    end else if (w_any) begin
      r_wr      <= '{x: req_X[w_idx], y: req_Y[w_idx], signal: req_signal[w_idx], sugar: req_sugar[w_idx]};
      r_wr_flag <= 1'b1;
    end else begin
      r_wr_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_env_port_sched.sv
// Directed bench for env_port_sched with a small behavioural model of the environment grid.
module tb_env_port_sched;
  import env_pkg::*;

  logic clk = 1'b0;
  logic rstN;
  logic [3:0]                   reqValid;
  logic [3:0][X_BITS-1:0]       reqX;
  logic [3:0][Y_BITS-1:0]       reqY;
  logic [3:0][SIGNAL_BITS-1:0]  reqSignal;
  logic [3:0]                   reqSugar;
  logic [3:0]                   reqGrant;
  logic                         decayStart, decayBusy, decayDone;
  logic [X_BITS-1:0]            antLookupX, lookupX, writeX;
  logic [Y_BITS-1:0]            antLookupY, lookupY, writeY;
  logic                         stall;
  logic [SIGNAL_BITS-1:0]       lookupSignal, writeSignal;
  logic                         lookupSugar, writeSugar, writeFlag;

  logic [SIGNAL_BITS-1:0] memSig   [PIXELS_Y][PIXELS_X];
  logic                   memSugar [PIXELS_Y][PIXELS_X];
  logic                   tbClr, tbWr, tbSugar;
  logic [X_BITS-1:0]      tbX;
  logic [Y_BITS-1:0]      tbY;
  logic [SIGNAL_BITS-1:0] tbSig;

  int checks = 0;
  int errors = 0;
  int grantCount;

  always #5 clk = ~clk;

  env_port_sched dut (
    .newLocClock      (clk),
    .RESET_SIM_N      (rstN),
    .req_valid        (reqValid),
    .req_X            (reqX),
    .req_Y            (reqY),
    .req_signal       (reqSignal),
    .req_sugar        (reqSugar),
    .req_grant        (reqGrant),
    .decay_start      (decayStart),
    .decay_busy       (decayBusy),
    .decay_done       (decayDone),
    .ant_lookup_X     (antLookupX),
    .ant_lookup_Y     (antLookupY),
    .ant_lookup_stall (stall),
    .lookup_X         (lookupX),
    .lookup_Y         (lookupY),
    .lookup_signal    (lookupSignal),
    .lookup_sugar     (lookupSugar),
    .write_X          (writeX),
    .write_Y          (writeY),
    .write_signal     (writeSignal),
    .write_sugar      (writeSugar),
    .write_flag       (writeFlag)
  );

  // Environment register file: commits the DUT write strobe, plus bench-side preload/clear.
  always @(posedge clk) begin
    if (tbClr) begin
      for (int y = 0; y < PIXELS_Y; y++)
        for (int x = 0; x < PIXELS_X; x++) begin
          memSig[y][x]   <= '0;
          memSugar[y][x] <= 1'b0;
        end
    end else if (tbWr) begin
      memSig[tbY][tbX]   <= tbSig;
      memSugar[tbY][tbX] <= tbSugar;
    end else if (writeFlag) begin
      memSig[writeY][writeX]   <= writeSignal;
      memSugar[writeY][writeX] <= writeSugar;
    end
  end

  assign lookupSignal = memSig[lookupY][lookupX];
  assign lookupSugar  = memSugar[lookupY][lookupX];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic start);
    reqValid   = valid;
    decayStart = start;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMem();
    tick(); tbClr = 1'b1;
    tick(); tbClr = 1'b0;
  endtask

  task automatic setCell(input int x, input int y, input int sig, input logic sug);
    tick();
    tbWr = 1'b1; tbX = X_BITS'(x); tbY = Y_BITS'(y); tbSig = SIGNAL_BITS'(sig); tbSugar = sug;
    tick();
    tbWr = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      if (decayDone) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd1);
    step();
  endtask

  task automatic startSweep();
    tick(); applyStimulus(4'b0000, 1'b1);
    tick(); applyStimulus(4'b0000, 1'b0);
  endtask

  initial begin
    rstN = 1'b0; reqValid = '0; reqX = '0; reqY = '0; reqSignal = '0; reqSugar = '0;
    decayStart = 1'b0; antLookupX = '0; antLookupY = '0;
    tbClr = 1'b0; tbWr = 1'b0; tbX = '0; tbY = '0; tbSig = '0; tbSugar = 1'b0;

    #12;
    checkOutput("rstWriteFlag", 32'(writeFlag), 32'd0);
    checkOutput("rstWriteX", 32'(writeX), 32'd0);
    checkOutput("rstWriteSig", 32'(writeSignal), 32'd0);
    checkOutput("rstBusy", 32'(decayBusy), 32'd0);
    checkOutput("rstDone", 32'(decayDone), 32'd0);
    checkOutput("rstStall", 32'(stall), 32'd0);
    checkOutput("rstGrant", 32'(reqGrant), 32'd0);
    tick(); rstN = 1'b1;

    // Round robin over requesters 0,1,3 held valid.
    reqX[0] = 2'd1; reqY[0] = 2'd0; reqSignal[0] = 4'd3; reqSugar[0] = 1'b0;
    reqX[1] = 2'd2; reqY[1] = 2'd0; reqSignal[1] = 4'd4; reqSugar[1] = 1'b0;
    reqX[3] = 2'd3; reqY[3] = 2'd3; reqSignal[3] = 4'd9; reqSugar[3] = 1'b1;
    tick(); applyStimulus(4'b1011, 1'b0);
    checkOutput("rrGrant0", 32'(reqGrant), 32'b0001);
    step();
    checkOutput("rrGrant1", 32'(reqGrant), 32'b0010);
    checkOutput("rrWrFlag0", 32'(writeFlag), 32'd1);
    checkOutput("rrWrX0", 32'(writeX), 32'd1);
    checkOutput("rrWrSig0", 32'(writeSignal), 32'd3);
    step();
    checkOutput("rrGrant3", 32'(reqGrant), 32'b1000);
    checkOutput("rrWrSig1", 32'(writeSignal), 32'd4);
    step();
    checkOutput("rrGrantWrap", 32'(reqGrant), 32'b0001);
    checkOutput("rrWrY3", 32'(writeY), 32'd3);
    checkOutput("rrWrSig3", 32'(writeSignal), 32'd9);
    checkOutput("rrWrSugar3", 32'(writeSugar), 32'd1);
    tick(); applyStimulus(4'b0000, 1'b0);
    checkOutput("rrLastWrFlag", 32'(writeFlag), 32'd1);
    checkOutput("rrLastWrX", 32'(writeX), 32'd1);
    checkOutput("rrNoGrant", 32'(reqGrant), 32'd0);
    step();
    checkOutput("rrFlagDrop", 32'(writeFlag), 32'd0);

    // Decay sweep: (2,1)=5 sugar 1 -> 4, (3,1)=1 -> 0, zero cells silent.
    clearMem();
    setCell(2, 1, 5, 1'b1);
    setCell(3, 1, 1, 1'b0);
    antLookupX = 2'd3; antLookupY = 2'd2;
    startSweep();
    checkOutput("decBusy", 32'(decayBusy), 32'd1);
    checkOutput("decStall", 32'(stall), 32'd1);
    checkOutput("decLookX00", 32'(lookupX), 32'd0);
    repeat (6) step();
    checkOutput("decLookX21", 32'(lookupX), 32'd2);
    checkOutput("decLookY21", 32'(lookupY), 32'd1);
    step();
    checkOutput("decWriteNoStall", 32'(stall), 32'd0);
    checkOutput("decAntLookX", 32'(lookupX), 32'd3);
    step();
    checkOutput("decWrFlag", 32'(writeFlag), 32'd1);
    checkOutput("decWrX", 32'(writeX), 32'd2);
    checkOutput("decWrY", 32'(writeY), 32'd1);
    checkOutput("decWrSig", 32'(writeSignal), 32'd4);
    checkOutput("decWrSugar", 32'(writeSugar), 32'd1);
    step();
    checkOutput("decIdleFlag", 32'(writeFlag), 32'd0);
    step();
    checkOutput("decOneFlag", 32'(writeFlag), 32'd1);
    checkOutput("decOneX", 32'(writeX), 32'd3);
    checkOutput("decOneSig", 32'(writeSignal), 32'd0);
    checkOutput("decOneSugar", 32'(writeSugar), 32'd0);
    tick(); applyStimulus(4'b0000, 1'b1);
    checkOutput("decZeroNoWrite", 32'(writeFlag), 32'd0);
    tick(); applyStimulus(4'b0000, 1'b0);
    repeat (5) step();
    checkOutput("decNotDoneYet", 32'(decayDone), 32'd0);
    step();
    checkOutput("decDone", 32'(decayDone), 32'd1);
    checkOutput("decBusyInDone", 32'(decayBusy), 32'd1);
    step();
    checkOutput("decDonePulse", 32'(decayDone), 32'd0);
    checkOutput("decIdle", 32'(decayBusy), 32'd0);
    antLookupX = '0; antLookupY = '0;

    // Empty grid: done 17 cycles after start, restart while busy ignored.
    clearMem();
    startSweep();
    repeat (6) step();
    tick(); applyStimulus(4'b0000, 1'b1);
    checkOutput("cmpBusy", 32'(decayBusy), 32'd1);
    tick(); applyStimulus(4'b0000, 1'b0);
    checkOutput("cmpNoWrite", 32'(writeFlag), 32'd0);
    repeat (7) step();
    checkOutput("cmpNotDone16", 32'(decayDone), 32'd0);
    step();
    checkOutput("cmpDone17", 32'(decayDone), 32'd1);
    step();
    checkOutput("cmpDonePulse", 32'(decayDone), 32'd0);
    checkOutput("cmpIdle", 32'(decayBusy), 32'd0);

    // Starvation: all ants hammer row 3 while the sweeper waits on (1,0).
    clearMem();
    setCell(1, 0, 3, 1'b0);
    setCell(3, 0, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      reqX[i] = X_BITS'(i); reqY[i] = 2'd3; reqSignal[i] = '0; reqSugar[i] = 1'b0;
    end
    startSweep();
    step();
    tick(); applyStimulus(4'b1111, 1'b0);
    checkOutput("stvFirstGrant", 32'(reqGrant), 32'b0010);
    grantCount = 0;
    for (int i = 0; i < 8; i++) begin
      if (reqGrant != 4'b0000) grantCount++;
      step();
    end
    checkOutput("stvGrantCount", 32'(grantCount), 32'd8);
    checkOutput("stvForcedNoGrant", 32'(reqGrant), 32'd0);
    checkOutput("stvForcedNoStall", 32'(stall), 32'd0);
    step();
    checkOutput("stvSweepFlag", 32'(writeFlag), 32'd1);
    checkOutput("stvSweepX", 32'(writeX), 32'd1);
    checkOutput("stvSweepY", 32'(writeY), 32'd0);
    checkOutput("stvSweepSig", 32'(writeSignal), 32'd2);
    checkOutput("stvReadGrant", 32'(reqGrant), 32'b0010);
    step();
    checkOutput("stvReadX30", 32'(lookupX), 32'd3);
    checkOutput("stvReadGrant2", 32'(reqGrant), 32'b0100);
    step();
    checkOutput("stvStarveReset", 32'(reqGrant), 32'b1000);
    tick(); applyStimulus(4'b0000, 1'b0);
    waitDone("stvDone", 40);

    // Hazard: ant 0 writes 7 to the sweep cell mid-write; sweeper re-reads and decays to 6.
    clearMem();
    setCell(1, 0, 3, 1'b0);
    reqX[0] = 2'd1; reqY[0] = 2'd0; reqSignal[0] = 4'd7; reqSugar[0] = 1'b1;
    startSweep();
    step();
    tick(); applyStimulus(4'b0001, 1'b0);
    checkOutput("hzdGrant", 32'(reqGrant), 32'b0001);
    tick(); applyStimulus(4'b0000, 1'b0);
    checkOutput("hzdAntFlag", 32'(writeFlag), 32'd1);
    checkOutput("hzdAntSig", 32'(writeSignal), 32'd7);
    checkOutput("hzdReread", 32'(stall), 32'd1);
    checkOutput("hzdRereadX", 32'(lookupX), 32'd1);
    step();
    checkOutput("hzdRetryStall", 32'(stall), 32'd1);
    checkOutput("hzdRetryX", 32'(lookupX), 32'd1);
    checkOutput("hzdRetryFlag", 32'(writeFlag), 32'd0);
    step();
    checkOutput("hzdWriteState", 32'(stall), 32'd0);
    step();
    checkOutput("hzdFinalFlag", 32'(writeFlag), 32'd1);
    checkOutput("hzdFinalX", 32'(writeX), 32'd1);
    checkOutput("hzdFinalY", 32'(writeY), 32'd0);
    checkOutput("hzdFinalSig", 32'(writeSignal), 32'd6);
    checkOutput("hzdFinalSugar", 32'(writeSugar), 32'd1);
    waitDone("hzdDone", 40);

    // Reset while the sweeper is about to write (1,0).
    clearMem();
    setCell(1, 0, 5, 1'b0);
    startSweep();
    step();
    tick(); rstN = 1'b0; #1;
    checkOutput("midRstBusy", 32'(decayBusy), 32'd0);
    checkOutput("midRstStall", 32'(stall), 32'd0);
    checkOutput("midRstFlag", 32'(writeFlag), 32'd0);
    checkOutput("midRstDone", 32'(decayDone), 32'd0);
    checkOutput("midRstGrant", 32'(reqGrant), 32'd0);
    tick(); rstN = 1'b1;
    step();
    checkOutput("postRstFlag", 32'(writeFlag), 32'd0);
    checkOutput("postRstBusy", 32'(decayBusy), 32'd0);
    startSweep();
    checkOutput("restartBusy", 32'(decayBusy), 32'd1);
    checkOutput("restartX", 32'(lookupX), 32'd0);
    checkOutput("restartY", 32'(lookupY), 32'd0);
    waitDone("restartDone", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
